// File: rtl/complex_product_checker.sv
// complex_product_checker: output-side checker for the data_start-framed
// complex multiplier. Samples operands on each accepted data_start, carries the
// exact expected product LATENCY cycles, compares it against the DUT result,
// and keeps pass/fail statistics plus the first failing vector.
module complex_product_checker #(
  parameter int LATENCY     = 2,
  parameter int NUM_VECTORS = 65536
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              data_start,
  input  logic signed [3:0] real_a,
  input  logic signed [3:0] image_a,
  input  logic signed [3:0] real_b,
  input  logic signed [3:0] image_b,
  input  logic signed [7:0] product_real,
  input  logic signed [7:0] product_image,
  output logic              check_valid,
  output logic              mismatch,
  output logic              error_flag,
  output logic [16:0]       pass_count,
  output logic [16:0]       error_count,
  output logic [31:0]       first_fail,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Field order doubles as the first_fail layout:
  // {real_a, real_b, image_a, image_b, exp_real, exp_image}.
  typedef struct packed {
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] ia;
    logic [3:0] ib;
    logic [7:0] er;
    logic [7:0] ei;
  } entry_t;

  // Products are formed at 9 bits so +128 (all operands -8) is exact before
  // the mod-2^8 reduction that the DUT outputs follow.
  function automatic logic [7:0] cplx_real(input logic signed [3:0] ra, input logic signed [3:0] rb,
                                           input logic signed [3:0] ia, input logic signed [3:0] ib);
    logic signed [8:0] acc;
    acc = 9'(ra) * 9'(rb) - 9'(ia) * 9'(ib);
    return acc[7:0];
  endfunction

  function automatic logic [7:0] cplx_imag(input logic signed [3:0] ra, input logic signed [3:0] rb,
                                           input logic signed [3:0] ia, input logic signed [3:0] ib);
    logic signed [8:0] acc;
    acc = 9'(ra) * 9'(ib) + 9'(ia) * 9'(rb);
    return acc[7:0];
  endfunction

  state_t         state_q, state_d;
  logic [LATENCY:1] vld_q, vld_d;
  entry_t         data_q [1:LATENCY];
  entry_t         data_d [1:LATENCY];
  logic           check_valid_q, check_valid_d;
  logic           mismatch_q, mismatch_d;
  logic           error_flag_q, error_flag_d;
  logic [16:0]    pass_count_q, pass_count_d;
  logic [16:0]    error_count_q, error_count_d;
  logic [31:0]    first_fail_q, first_fail_d;
  logic           neq;
  logic [17:0]    total_next;

  assign neq        = (data_q[LATENCY].er != product_real) || (data_q[LATENCY].ei != product_image);
  assign total_next = {1'b0, pass_count_q} + {1'b0, error_count_q} + 18'd1;

  // Next-state, pipeline shift, compare and statistics update.
  always_comb begin
    state_d       = state_q;
    vld_d         = vld_q;
    data_d        = data_q;
    check_valid_d = 1'b0;
    mismatch_d    = 1'b0;
    error_flag_d  = error_flag_q;
    pass_count_d  = pass_count_q;
    error_count_d = error_count_q;
    first_fail_d  = first_fail_q;

    for (int i = LATENCY; i >= 2; i--) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
    vld_d[1]  = (state_q == RUN) && data_start;
    data_d[1] = '{ra: real_a, rb: real_b, ia: image_a, ib: image_b,
                  er: cplx_real(real_a, real_b, image_a, image_b),
                  ei: cplx_imag(real_a, real_b, image_a, image_b)};

    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (vld_q[LATENCY]) begin
          check_valid_d = 1'b1;
          mismatch_d    = neq;
          if (neq) begin
            error_count_d = error_count_q + 17'd1;
            if (!error_flag_q) begin
              error_flag_d = 1'b1;
              first_fail_d = data_q[LATENCY];
            end
          end else begin
            pass_count_d = pass_count_q + 17'd1;
          end
          if (total_next == 18'(NUM_VECTORS)) state_d = DONE;
        end
      end
      default: ;
    endcase

    // Outside RUN nothing is accepted and anything in flight is dropped.
    if (state_q != RUN) vld_d = '0;

    if (clear) begin
      state_d       = IDLE;
      vld_d         = '0;
      check_valid_d = 1'b0;
      mismatch_d    = 1'b0;
      error_flag_d  = 1'b0;
      pass_count_d  = '0;
      error_count_d = '0;
      first_fail_d  = '0;
    end
  end

  // Control and result registers; cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      vld_q         <= '0;
      check_valid_q <= 1'b0;
      mismatch_q    <= 1'b0;
      error_flag_q  <= 1'b0;
      pass_count_q  <= '0;
      error_count_q <= '0;
      first_fail_q  <= '0;
    end else begin
      state_q       <= state_d;
      vld_q         <= vld_d;
      check_valid_q <= check_valid_d;
      mismatch_q    <= mismatch_d;
      error_flag_q  <= error_flag_d;
      pass_count_q  <= pass_count_d;
      error_count_q <= error_count_d;
      first_fail_q  <= first_fail_d;
    end
  end

  // Operand/expected-value payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign check_valid = check_valid_q;
  assign mismatch    = mismatch_q;
  assign error_flag  = error_flag_q;
  assign pass_count  = pass_count_q;
  assign error_count = error_count_q;
  assign first_fail  = first_fail_q;
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_complex_product_checker.sv
// Directed bench for complex_product_checker (LATENCY=2, NUM_VECTORS=4).
// A two-stage delay line stands in for the multiplier so each strobe's
// response reaches product_* exactly on its compare edge.
module tb_complex_product_checker;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic        data_start = 1'b0;
  logic [3:0]  real_a = '0, image_a = '0, real_b = '0, image_b = '0;
  logic [7:0]  drv_r = '0, drv_i = '0, d1_r = '0, d1_i = '0, d2_r = '0, d2_i = '0;
  logic        check_valid, mismatch, error_flag, done;
  logic [16:0] pass_count, error_count;
  logic [31:0] first_fail;

  int checks = 0;
  int errors = 0;

  complex_product_checker #(.LATENCY(2), .NUM_VECTORS(4)) dut (
    .clk(clk), .Reset(Reset), .enable(enable), .clear(clear), .data_start(data_start),
    .real_a(real_a), .image_a(image_a), .real_b(real_b), .image_b(image_b),
    .product_real(d2_r), .product_image(d2_i),
    .check_valid(check_valid), .mismatch(mismatch), .error_flag(error_flag),
    .pass_count(pass_count), .error_count(error_count), .first_fail(first_fail), .done(done)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: response presented two cycles after its strobe is sampled.
  always @(posedge clk) begin
    d1_r <= drv_r; d1_i <= drv_i;
    d2_r <= d1_r;  d2_i <= d1_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe starting at a negedge; returns at the following negedge.
  task automatic send(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] ia,
                      input logic [3:0] ib, input logic [7:0] pr, input logic [7:0] pi);
    data_start = 1'b1;
    real_a = ra; real_b = rb; image_a = ia; image_b = ib;
    drv_r = pr; drv_i = pi;
    @(negedge clk);
    data_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(3);
    check_eq("rst_cv", 32'(check_valid), 32'd0);
    check_eq("rst_flag", 32'(error_flag), 32'd0);
    check_eq("rst_pass", 32'(pass_count), 32'd0);
    check_eq("rst_err", 32'(error_count), 32'd0);
    check_eq("rst_ff", first_fail, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    Reset  = 1'b1;
    enable = 1'b1;
    idle(1);

    // Single passing vector: 3,2,1,-1 -> 07/FF
    send(4'h3, 4'h2, 4'h1, 4'hF, 8'h07, 8'hFF);
    idle(1);
    check_eq("t1_cv_early", 32'(check_valid), 32'd0);
    idle(1);
    check_eq("t1_cv", 32'(check_valid), 32'd1);
    check_eq("t1_mm", 32'(mismatch), 32'd0);
    check_eq("t1_pass", 32'(pass_count), 32'd1);
    idle(1);
    check_eq("t1_cv_pulse", 32'(check_valid), 32'd0);

    // Same vector, wrong imaginary part
    send(4'h3, 4'h2, 4'h1, 4'hF, 8'h07, 8'h01);
    idle(2);
    check_eq("t2_cv", 32'(check_valid), 32'd1);
    check_eq("t2_mm", 32'(mismatch), 32'd1);
    check_eq("t2_flag", 32'(error_flag), 32'd1);
    check_eq("t2_err", 32'(error_count), 32'd1);
    check_eq("t2_ff", first_fail, 32'h321F_07FF);
    idle(1);
    check_eq("t2_mm_pulse", 32'(mismatch), 32'd0);

    // All -8: exp_real 0, exp_image 128 -> 8'h80
    send(4'h8, 4'h8, 4'h8, 4'h8, 8'h00, 8'h80);
    idle(2);
    check_eq("t3_cv", 32'(check_valid), 32'd1);
    check_eq("t3_mm", 32'(mismatch), 32'd0);
    check_eq("t3_pass", 32'(pass_count), 32'd2);
    check_eq("t3_done", 32'(done), 32'd0);

    do_clear();
    check_eq("clr1_pass", 32'(pass_count), 32'd0);
    check_eq("clr1_err", 32'(error_count), 32'd0);
    check_eq("clr1_flag", 32'(error_flag), 32'd0);
    check_eq("clr1_ff", first_fail, 32'd0);
    idle(1);

    // Back-to-back: A pass (F6/0A), B fail (exp 01/0D), C pass (00/62)
    send(4'h1, 4'h2, 4'h3, 4'h4, 8'hF6, 8'h0A);
    send(4'hF, 4'h5, 4'h2, 4'hD, 8'h01, 8'h0C);
    send(4'h7, 4'h7, 4'h7, 4'h7, 8'h00, 8'h62);
    check_eq("t4a_cv", 32'(check_valid), 32'd1);
    check_eq("t4a_mm", 32'(mismatch), 32'd0);
    check_eq("t4a_pass", 32'(pass_count), 32'd1);
    idle(1);
    check_eq("t4b_cv", 32'(check_valid), 32'd1);
    check_eq("t4b_mm", 32'(mismatch), 32'd1);
    check_eq("t4b_err", 32'(error_count), 32'd1);
    check_eq("t4b_ff", first_fail, 32'hF52D_010D);
    idle(1);
    check_eq("t4c_cv", 32'(check_valid), 32'd1);
    check_eq("t4c_mm", 32'(mismatch), 32'd0);
    check_eq("t4c_pass", 32'(pass_count), 32'd2);
    idle(1);
    check_eq("t4_cv_end", 32'(check_valid), 32'd0);

    do_clear();
    idle(1);

    // Five strobes with NUM_VECTORS=4: done after the 4th, 5th dropped
    send(4'h1, 4'h2, 4'h3, 4'h4, 8'hF6, 8'h0A);
    send(4'h7, 4'h7, 4'h7, 4'h7, 8'h00, 8'h62);
    send(4'h1, 4'h2, 4'h3, 4'h4, 8'hF6, 8'h0A);
    send(4'h7, 4'h7, 4'h7, 4'h7, 8'h00, 8'h62);
    send(4'h1, 4'h2, 4'h3, 4'h4, 8'hF6, 8'h0A);
    check_eq("t5_pass3", 32'(pass_count), 32'd3);
    check_eq("t5_done_early", 32'(done), 32'd0);
    idle(1);
    check_eq("t5_pass4", 32'(pass_count), 32'd4);
    check_eq("t5_done", 32'(done), 32'd1);
    idle(1);
    check_eq("t5_cv5", 32'(check_valid), 32'd0);
    check_eq("t5_pass_hold", 32'(pass_count), 32'd4);
    send(4'h1, 4'h2, 4'h3, 4'h4, 8'hF6, 8'h0A);
    idle(3);
    check_eq("t5_done_hold", 32'(done), 32'd1);
    check_eq("t5_pass_final", 32'(pass_count), 32'd4);

    enable = 1'b0;
    do_clear();
    check_eq("clr3_done", 32'(done), 32'd0);
    check_eq("clr3_pass", 32'(pass_count), 32'd0);

    // clear on the compare edge of a pending mismatch
    enable = 1'b1;
    idle(1);
    enable = 1'b0;
    send(4'hF, 4'h5, 4'h2, 4'hD, 8'h01, 8'h0C);
    idle(1);
    do_clear();
    check_eq("t6_cv", 32'(check_valid), 32'd0);
    check_eq("t6_err", 32'(error_count), 32'd0);
    check_eq("t6_flag", 32'(error_flag), 32'd0);
    check_eq("t6_pass", 32'(pass_count), 32'd0);
    check_eq("t6_ff", first_fail, 32'd0);
    // Back in IDLE with enable low: strobe ignored
    send(4'h1, 4'h2, 4'h3, 4'h4, 8'hF6, 8'h0A);
    idle(2);
    check_eq("t6_idle_cv", 32'(check_valid), 32'd0);
    check_eq("t6_idle_pass", 32'(pass_count), 32'd0);
    // Re-arm; new first failure captured, later failure does not overwrite it
    enable = 1'b1;
    idle(1);
    enable = 1'b0;
    send(4'h7, 4'h7, 4'h7, 4'h7, 8'h00, 8'h63);
    idle(2);
    check_eq("t6_mm", 32'(mismatch), 32'd1);
    check_eq("t6_err1", 32'(error_count), 32'd1);
    check_eq("t6_ff_new", first_fail, 32'h7777_0062);
    send(4'hF, 4'h5, 4'h2, 4'hD, 8'h01, 8'h0C);
    idle(2);
    check_eq("t6_mm2", 32'(mismatch), 32'd1);
    check_eq("t6_err2", 32'(error_count), 32'd2);
    check_eq("t6_ff_keep", first_fail, 32'h7777_0062);

    // Asynchronous reset mid-run clears everything
    Reset = 1'b0;
    #1;
    check_eq("rst2_err", 32'(error_count), 32'd0);
    check_eq("rst2_ff", first_fail, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
